// File: rtl/imm_narrow_pack.sv
// Narrows 16-bit signed values to 4-bit fields and packs four per output word, LSB lane first.
// Define NARROW_SAT_EN to saturate out-of-range values; otherwise they are truncated.
module imm_narrow_pack #(
  parameter int IN_W     = 16,
  parameter int NARROW_W = 4,
  parameter int LANES    = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W-1:0]           in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NARROW_W*LANES-1:0] out_data,
  output logic [2:0]                out_count,
  output logic [LANES-1:0]          out_ovf,
  output logic [7:0]                ovf_cnt
);

  localparam int IDX_W = $clog2(LANES);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx;
  logic signed [IN_W-1:0]  in_val;
  logic                    accept;
  logic                    close;
  logic                    val_ok;
  logic [NARROW_W-1:0]     field;

  // The value fits iff every bit from the field's sign bit upward is a copy of it.
  function automatic logic in_range(input logic signed [IN_W-1:0] v);
    logic [IN_W-NARROW_W:0] top;
    top = v[IN_W-1:NARROW_W-1];
    return (&top) || (~|top);
  endfunction

  function automatic logic [NARROW_W-1:0] narrow(input logic signed [IN_W-1:0] v);
`ifdef NARROW_SAT_EN
    if (!in_range(v))
      return v[IN_W-1] ? {1'b1, {(NARROW_W-1){1'b0}}} : {1'b0, {(NARROW_W-1){1'b1}}};
`endif
    return v[NARROW_W-1:0];
  endfunction

  assign in_val    = in_data;
  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign close     = in_last || (idx == IDX_W'(LANES-1));
  assign val_ok    = in_range(in_val);
  assign field     = narrow(in_val);

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (accept && close) state_nxt = HOLD;
      HOLD: if (out_ready)       state_nxt = FILL;
      default:                   state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FILL;
      idx       <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= '0;
      ovf_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_data[idx*NARROW_W +: NARROW_W] <= field;
        out_ovf[idx]                       <= !val_ok;
        if (close) begin
          out_count <= 3'(idx) + 3'd1;
          idx       <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
        if (!val_ok && ovf_cnt != 8'hFF)
          ovf_cnt <= ovf_cnt + 8'd1;
      end else if (out_valid && out_ready) begin
        // Word consumed: clear lanes so a short next word has zero upper lanes.
        out_data  <= '0;
        out_count <= '0;
        out_ovf   <= '0;
        idx       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imm_narrow_pack.sv
// Randomized and directed bench for imm_narrow_pack against an integer-level packing model.
module tb_imm_narrow_pack;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_count;
  logic [3:0]  out_ovf;
  logic [7:0]  ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  imm_narrow_pack dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit ref_ovf(int v);
    return (v < -8) || (v > 7);
  endfunction

  function automatic logic [3:0] ref_field(int v);
    logic [31:0] t;
    t = v;
`ifdef NARROW_SAT_EN
    if (v > 7)  return 4'd7;
    if (v < -8) return 4'd8;
`endif
    return t[3:0];
  endfunction

  function automatic int rand_val();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 15)) - 8;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic send(input int v, input bit last);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(v);
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready %b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (ref_ovf(v) && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic recv(output logic [15:0] d, output logic [2:0] c, output logic [3:0] o);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL recv_timeout: out_valid %b after %0d cycles, required 1", out_valid, n);
    end
    d = out_data; c = out_count; o = out_ovf;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL rst_out_data: got %h required 0000", out_data); end
    n_checks++; if (out_count !== 3'd0) begin n_fail++; $display("FAIL rst_out_count: got %0d required 0", out_count); end
    n_checks++; if (out_ovf !== 4'h0) begin n_fail++; $display("FAIL rst_out_ovf: got %b required 0000", out_ovf); end
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_ovf_cnt: got %0d required 0", ovf_cnt); end
    reset_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_pack_basic();
    logic [15:0] d; logic [2:0] c; logic [3:0] o;
    send(3, 0); send(-2, 0); send(7, 0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b required 0", out_valid); end
    send(-8, 0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: out_valid %b required 1", out_valid); end
    recv(d, c, o);
    n_checks++; if (d !== 16'h87E3) begin n_fail++; $display("FAIL basic_data: got %h required 87e3", d); end
    n_checks++; if (c !== 3'd4) begin n_fail++; $display("FAIL basic_count: got %0d required 4", c); end
    n_checks++; if (o !== 4'b0000) begin n_fail++; $display("FAIL basic_ovf: got %b required 0000", o); end
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_ovf_cnt: got %0d required 0", ovf_cnt); end
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic [2:0] c; logic [3:0] o; logic [15:0] want;
`ifdef NARROW_SAT_EN
    want = 16'h0087;
`else
    want = 16'h0000;
`endif
    send(32, 0); send(-256, 1);
    recv(d, c, o);
    n_checks++; if (d !== want) begin n_fail++; $display("FAIL ovf_data: got %h required %h", d, want); end
    n_checks++; if (c !== 3'd2) begin n_fail++; $display("FAIL ovf_count: got %0d required 2", c); end
    n_checks++; if (o !== 4'b0011) begin n_fail++; $display("FAIL ovf_flags: got %b required 0011", o); end
    n_checks++; if (ovf_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_cnt: got %0d required 2", ovf_cnt); end
  endtask

  task automatic test_last();
    logic [15:0] d; logic [2:0] c; logic [3:0] o;
    send(5, 0); send(1, 1);
    recv(d, c, o);
    n_checks++; if (d !== 16'h0015) begin n_fail++; $display("FAIL last_data: got %h required 0015", d); end
    n_checks++; if (c !== 3'd2) begin n_fail++; $display("FAIL last_count: got %0d required 2", c); end
    n_checks++; if (o !== 4'b0000) begin n_fail++; $display("FAIL last_ovf: got %b required 0000", o); end
    send(2, 1);
    recv(d, c, o);
    n_checks++; if (d !== 16'h0002 || c !== 3'd1) begin n_fail++; $display("FAIL last_next_lane0: got %h/%0d required 0002/1", d, c); end
    send(1, 0); send(2, 0); send(3, 0); send(4, 1);
    recv(d, c, o);
    n_checks++; if (d !== 16'h4321 || c !== 3'd4) begin n_fail++; $display("FAIL last_at_lane3: got %h/%0d required 4321/4", d, c); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL last_no_extra_word: out_valid %b required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [15:0] d0; logic [2:0] c0; logic [3:0] o0;
    send(-1, 0); send(0, 0); send(6, 0); send(-5, 0);
    d0 = out_data; c0 = out_count; o0 = out_ovf;
    n_checks++; if (d0 !== 16'hB60F) begin n_fail++; $display("FAIL bp_data: got %h required b60f", d0); end
    in_valid = 1'b1; in_data = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_data !== d0 || out_count !== c0 || out_ovf !== o0) begin
        n_fail++; $display("FAIL bp_stable: got %b/%h/%0d/%b required 1/%h/%0d/%b", out_valid, out_data, out_count, out_ovf, d0, c0, o0);
      end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
      n_checks++; if (ovf_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL bp_ovf_cnt: got %0d required %0d", ovf_cnt, exp_cnt); end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: in_ready %b out_valid %b required 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_midword();
    logic [15:0] d; logic [2:0] c; logic [3:0] o;
    send(3, 0); send(-100, 0);
    n_checks++; if (ovf_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL mid_ovf_pre: got %0d required %0d", ovf_cnt, exp_cnt); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
    n_checks++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_ovf_cnt: got %0d required 0", ovf_cnt); end
    @(negedge clk);
    reset_n = 1'b1;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    recv(d, c, o);
    n_checks++; if (d !== 16'h4321 || c !== 3'd4 || o !== 4'h0) begin n_fail++; $display("FAIL mid_clean_word: got %h/%0d/%b required 4321/4/0000", d, c, o); end
  endtask

  task automatic test_random();
    logic [15:0] d, wd; logic [2:0] c; logic [3:0] o, wo;
    int k, v;
    bit last;
    for (int w = 0; w < 40; w++) begin
      k = $urandom_range(1, 4);
      wd = '0; wo = '0;
      for (int j = 0; j < k; j++) begin
        v = rand_val();
        wd[j*4 +: 4] = ref_field(v);
        wo[j] = ref_ovf(v);
        last = (j == k - 1) && (k < 4 || $urandom_range(0, 1) == 1);
        send(v, last);
      end
      recv(d, c, o);
      n_checks++; if (d !== wd || c !== 3'(k) || o !== wo) begin
        n_fail++; $display("FAIL rand_word%0d: got %h/%0d/%b required %h/%0d/%b", w, d, c, o, wd, k, wo);
      end
      n_checks++; if (ovf_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL rand_ovf_cnt%0d: got %0d required %0d", w, ovf_cnt, exp_cnt); end
    end
  endtask

  task automatic test_ovf_saturate();
    logic [15:0] d; logic [2:0] c; logic [3:0] o;
    for (int i = 0; i < 300; i++) begin
      send(((i % 2) == 0) ? 100 : -3000, (i % 4) == 3);
      if ((i % 4) == 3) recv(d, c, o);
      if (i == 99) begin
        n_checks++; if (ovf_cnt !== 8'(exp_cnt)) begin n_fail++; $display("FAIL sat_mid: got %0d required %0d", ovf_cnt, exp_cnt); end
      end
    end
    n_checks++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d required 255", ovf_cnt); end
    send(50, 1);
    recv(d, c, o);
    n_checks++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d required 255", ovf_cnt); end
    n_checks++; if (o !== 4'b0001 || c !== 3'd1) begin n_fail++; $display("FAIL sat_flag: got %b/%0d required 0001/1", o, c); end
  endtask

  initial begin
    test_reset();
    test_pack_basic();
    test_overflow();
    test_last();
    test_backpressure();
    test_reset_midword();
    test_random();
    test_ovf_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
